// File: rtl/mem_io_responder.sv
// mem_io_responder: CPU memory-port responder with word RAM, TX FIFO, RX holding register,
// status register and cycle counter in a 4-word I/O page; reads are combinational.
module mem_io_responder #(
  parameter int          RAM_DEPTH = 4096,
  parameter logic [15:0] IO_BASE   = 16'hFF00,
  parameter int          TX_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic        we,
  input  logic        re,
  input  logic [15:0] writeData,
  output logic [15:0] readData,
  output logic [15:0] txData,
  output logic        txValid,
  input  logic        txReady,
  input  logic [15:0] rxData,
  input  logic        rxValid,
  output logic        rxReady
);
  localparam int AW = $clog2(RAM_DEPTH);
  localparam int PW = $clog2(TX_DEPTH);
  localparam logic [16:0] RAM_END = 17'(RAM_DEPTH);

  logic [15:0] ram [RAM_DEPTH];
  logic [15:0] txBuf [TX_DEPTH];
  logic [PW:0] wp, rp;
  logic [15:0] rxHold, cycles;
  logic rxFull, overflow, txEmpty, txFull;
  logic isRam, ioHit, push, pop, rxCapture, rxPop, cycWrite, statusWrite;
  logic [15:0] status;

  assign isRam = {1'b0, addr} < RAM_END;
  assign ioHit = addr[15:2] == IO_BASE[15:2];
  assign txEmpty = wp == rp;
  assign txFull = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign txValid = !txEmpty;
  assign txData = txBuf[rp[PW-1:0]];
  assign rxReady = !rxFull;
  assign pop = txValid && txReady;
  assign push = we && ioHit && addr[1:0] == 2'd0;
  assign statusWrite = we && ioHit && addr[1:0] == 2'd1;
  assign rxPop = re && rxFull && ioHit && addr[1:0] == 2'd2;
  assign cycWrite = we && ioHit && addr[1:0] == 2'd3;
  assign rxCapture = rxValid && !rxFull;
  assign status = {12'b0, overflow, rxFull, txFull, txEmpty};

  always_comb begin
    readData = isRam ? ram[addr[AW-1:0]] :
               !ioHit ? 16'h0 :
               addr[1:0] == 2'd1 ? status :
               addr[1:0] == 2'd2 ? (rxFull ? rxHold : 16'h0) :
               addr[1:0] == 2'd3 ? cycles : 16'h0;
  end

  always_ff @(posedge clk) begin
    if (we && isRam) ram[addr[AW-1:0]] <= writeData;
    if (push && (!txFull || pop)) txBuf[wp[PW-1:0]] <= writeData;
    if (rxCapture) rxHold <= rxData;
  end

  // a full FIFO still accepts a push when the head leaves in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      rxFull <= 1'b0;
      overflow <= 1'b0;
      cycles <= 16'h0;
    end else begin
      if (push && (!txFull || pop)) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (push && txFull && !pop) overflow <= 1'b1;
      else if (statusWrite) overflow <= 1'b0;
      if (rxCapture) rxFull <= 1'b1;
      else if (rxPop) rxFull <= 1'b0;
      cycles <= cycWrite ? 16'h0 : cycles + 16'h1;
    end
  end
endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder: table-driven per-cycle vectors plus hand sequences for counter wrap and reset.
module tb_mem_io_responder;
  logic clk = 0, rst = 1;
  logic [15:0] addr = 16'h2000, writeData = 0, rxData = 0;
  logic we = 0, re = 0, txReady = 0, rxValid = 0;
  logic [15:0] readData, txData;
  logic txValid, rxReady;
  int total = 0, bad = 0;

  localparam logic [15:0] T = 16'hFF00, S = 16'hFF01, R = 16'hFF02, C = 16'hFF03, Z = 16'h2000;

  mem_io_responder dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re), .writeData(writeData),
    .readData(readData), .txData(txData), .txValid(txValid), .txReady(txReady),
    .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic w, r;
    logic [15:0] wd;
    logic txr, rxv;
    logic [15:0] rxd;
    logic chkRd;
    logic [15:0] rd;
    logic txv;
    logic [15:0] txd;
    logic rxr;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input logic [15:0] a, input logic w, r, input logic [15:0] wd,
                     input logic txr, rxv, input logic [15:0] rxd, input logic chkRd,
                     input logic [15:0] rd, input logic txv, input logic [15:0] txd,
                     input logic rxr);
    vec_t v;
    v.a = a; v.w = w; v.r = r; v.wd = wd; v.txr = txr; v.rxv = rxv; v.rxd = rxd;
    v.chkRd = chkRd; v.rd = rd; v.txv = txv; v.txd = txd; v.rxr = rxr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [15:0] act, exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic idle();
    addr = Z; we = 0; re = 0; writeData = 0; txReady = 0; rxValid = 0; rxData = 0;
  endtask

  initial begin
    //   addr we re wd       txr rxv rxd     ck rd       txv txd      rxr
    add(16'h0010, 1, 0, 16'hBEEF, 0, 0, 0, 0, 0, 0, 0, 1);
    add(16'h0010, 0, 0, 0, 0, 0, 0, 1, 16'hBEEF, 0, 0, 1);
    add(Z, 0, 0, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 1);
    add(16'hFF05, 1, 1, 16'h1234, 0, 0, 0, 1, 16'h0000, 0, 0, 1);
    add(S, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 0, 0, 1);
    add(T, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1);
    add(T, 1, 0, 2, 0, 0, 0, 1, 0, 1, 1, 1);
    add(T, 1, 0, 3, 0, 0, 0, 1, 0, 1, 1, 1);
    add(T, 1, 0, 4, 0, 0, 0, 1, 0, 1, 1, 1);
    add(S, 0, 0, 0, 0, 0, 0, 1, 16'h0002, 1, 1, 1);
    add(T, 1, 0, 5, 0, 0, 0, 1, 0, 1, 1, 1);
    add(S, 0, 0, 0, 0, 0, 0, 1, 16'h000A, 1, 1, 1);
    add(S, 0, 0, 0, 1, 0, 0, 1, 16'h000A, 1, 1, 1);
    add(Z, 0, 0, 0, 1, 0, 0, 1, 0, 1, 2, 1);
    add(Z, 0, 0, 0, 1, 0, 0, 1, 0, 1, 3, 1);
    add(Z, 0, 0, 0, 1, 0, 0, 1, 0, 1, 4, 1);
    add(S, 0, 0, 0, 1, 0, 0, 1, 16'h0009, 0, 0, 1);
    add(S, 1, 0, 16'h5555, 0, 0, 0, 1, 16'h0009, 0, 0, 1);
    add(S, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 0, 0, 1);
    add(T, 1, 0, 6, 0, 0, 0, 1, 0, 0, 0, 1);
    add(T, 1, 0, 7, 0, 0, 0, 1, 0, 1, 6, 1);
    add(T, 1, 0, 8, 0, 0, 0, 1, 0, 1, 6, 1);
    add(T, 1, 0, 11, 0, 0, 0, 1, 0, 1, 6, 1);
    add(T, 1, 0, 9, 1, 0, 0, 1, 0, 1, 6, 1);
    add(S, 0, 0, 0, 0, 0, 0, 1, 16'h0002, 1, 7, 1);
    add(Z, 0, 0, 0, 1, 0, 0, 1, 0, 1, 7, 1);
    add(Z, 0, 0, 0, 1, 0, 0, 1, 0, 1, 8, 1);
    add(Z, 0, 0, 0, 1, 0, 0, 1, 0, 1, 11, 1);
    add(Z, 0, 0, 0, 1, 0, 0, 1, 0, 1, 9, 1);
    add(S, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 0, 0, 1);
    add(R, 0, 0, 0, 0, 1, 16'h0041, 1, 16'h0000, 0, 0, 1);
    add(S, 0, 0, 0, 0, 1, 16'h0099, 1, 16'h0005, 0, 0, 0);
    add(R, 1, 0, 16'h7777, 0, 0, 0, 1, 16'h0041, 0, 0, 0);
    add(S, 0, 0, 0, 0, 0, 0, 1, 16'h0005, 0, 0, 0);
    add(R, 0, 1, 0, 0, 0, 0, 1, 16'h0041, 0, 0, 0);
    add(S, 0, 0, 0, 0, 0, 0, 1, 16'h0001, 0, 0, 1);
    add(R, 0, 1, 0, 0, 0, 0, 1, 16'h0000, 0, 0, 1);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_txValid", 16'(txValid), 16'h0);
    chk("rst_rxReady", 16'(rxReady), 16'h1);
    addr = S; #1;
    chk("rst_status", readData, 16'h0001);
    rst = 0; addr = C; #1;
    chk("cycles_at_0", readData, 16'h0000);
    repeat (5) @(negedge clk);
    #1;
    chk("cycles_at_5", readData, 16'h0005);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      addr = vecs[i].a; we = vecs[i].w; re = vecs[i].r; writeData = vecs[i].wd;
      txReady = vecs[i].txr; rxValid = vecs[i].rxv; rxData = vecs[i].rxd;
      #1;
      if (vecs[i].chkRd) chk($sformatf("v%0d_readData", i), readData, vecs[i].rd);
      chk($sformatf("v%0d_txValid", i), 16'(txValid), 16'(vecs[i].txv));
      if (vecs[i].txv) chk($sformatf("v%0d_txData", i), txData, vecs[i].txd);
      chk($sformatf("v%0d_rxReady", i), 16'(rxReady), 16'(vecs[i].rxr));
    end

    @(negedge clk);
    idle(); addr = C; we = 1; writeData = 16'hABCD;
    @(negedge clk);
    idle(); addr = C; #1;
    chk("cyc_clear", readData, 16'h0000);
    @(negedge clk); #1;
    chk("cyc_after_clear", readData, 16'h0001);
    we = 1;
    @(negedge clk);
    we = 0; #1;
    chk("cyc_clear2", readData, 16'h0000);
    repeat (65535) @(negedge clk);
    #1;
    chk("cyc_ffff", readData, 16'hFFFF);
    @(negedge clk); #1;
    chk("cyc_wrap", readData, 16'h0000);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      idle(); addr = T; we = 1; writeData = 16'(i + 16'h20);
      rxValid = (i == 0); rxData = 16'h1234;
    end
    @(negedge clk);
    idle(); #1;
    chk("pre_rst_txValid", 16'(txValid), 16'h1);
    chk("pre_rst_rxReady", 16'(rxReady), 16'h0);
    rst = 1;
    @(negedge clk);
    rst = 0; #1;
    chk("mid_rst_txValid", 16'(txValid), 16'h0);
    chk("mid_rst_rxReady", 16'(rxReady), 16'h1);
    addr = S; #1;
    chk("mid_rst_status", readData, 16'h0001);
    addr = C; #1;
    chk("mid_rst_cycles", readData, 16'h0000);
    addr = R; #1;
    chk("mid_rst_rxdata", readData, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
